// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared types and helpers for the multi-flux FIFO read scheduler
package fifo_sched_pkg;

    typedef enum logic {IDLE, SERVE} state_t;

    function automatic int tag_w(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic logic [31:0] onehot(input int idx, input int flux);
        return (idx >= 0 && idx < flux) ? (32'd1 << idx) : 32'd0;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: first set request bit found searching cyclically from a start index
module fifo_rr_pick #(
    parameter int FLUX = 2,
    parameter int IW   = 1
) (
    input  logic [FLUX-1:0] i_req,
    input  logic [IW-1:0]   i_start,
    output logic            o_found,
    output logic [IW-1:0]   o_idx
);

    logic [2*FLUX-1:0] w_dbl;
    int                w_s;

    assign w_dbl = {i_req, i_req} >> i_start;

    // Descending scan so the nearest request (smallest offset) wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_s     = 0;
        for (int k = FLUX - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_s     = int'(i_start) + k;
                o_found = 1'b1;
                o_idx   = IW'(w_s >= FLUX ? w_s - FLUX : w_s);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: quantum round-robin read scheduler for the shared multi-flux FIFO
module fifo_rd_sched
    import fifo_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int QUANTUM    = 4,
    parameter int TAG_WIDTH  = tag_w(FLUX)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic [FLUX-1:0]                 i_fifo_empty,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] i_fifo_dout,
    output logic [FLUX-1:0]                 o_fifo_read,
    output logic [FLUX-1:0]                 o_out_valid,
    output logic [FLUX-1:0][DATA_WIDTH-1:0] o_out_data,
    input  logic [FLUX-1:0]                 i_out_ready,
    output logic [TAG_WIDTH-1:0]            o_cur_flux,
    output logic                            o_busy,
    output logic                            o_tag_err
);

    localparam int BW = $clog2(QUANTUM + 1);

    state_t                 r_state;
    logic [TAG_WIDTH-1:0]   r_cur;
    logic [TAG_WIDTH-1:0]   r_rr;
    logic [BW-1:0]          r_burst;

    logic [FLUX-1:0]        w_elig;
    logic [TAG_WIDTH-1:0]   w_nxt;
    logic [TAG_WIDTH-1:0]   w_start;
    logic [TAG_WIDTH-1:0]   w_pick;
    logic [TAG_WIDTH-1:0]   w_idx;
    logic                   w_found;
    logic                   w_stay;
    logic                   w_gnt;

    assign w_elig  = {FLUX{i_en}} & ~i_fifo_empty & (~o_out_valid | i_out_ready);
    assign w_nxt   = (int'(r_cur) == FLUX - 1) ? '0 : r_cur + 1'b1;
    assign w_start = (r_state == IDLE) ? r_rr : w_nxt;

    fifo_rr_pick #(.FLUX(FLUX), .IW(TAG_WIDTH)) u_pick (
        .i_req   (w_elig),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_stay = (r_state == SERVE) && w_elig[r_cur] && (int'(r_burst) < QUANTUM);
    assign w_idx  = w_stay ? r_cur : w_pick;
    // Gating with reset keeps the strobe low while reset is held.
    assign w_gnt  = i_rst_n & (w_stay | w_found);

    assign o_fifo_read = w_gnt ? FLUX'(onehot(int'(w_idx), FLUX)) : '0;
    assign o_cur_flux  = r_cur;
    assign o_busy      = (r_state == SERVE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_burst <= '0;
            r_rr    <= '0;
        end else if (w_gnt) begin
            r_state <= SERVE;
            r_cur   <= w_idx;
            r_burst <= w_stay ? r_burst + 1'b1 : BW'(1);
        end else if (r_state == SERVE) begin
            r_state <= IDLE;
            r_rr    <= w_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid <= '0;
            o_out_data  <= '0;
            o_tag_err   <= 1'b0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (o_fifo_read[f]) begin
                    o_out_data[f]  <= i_fifo_dout[DATA_WIDTH-1:0];
                    o_out_valid[f] <= 1'b1;
                end else if (i_out_ready[f]) begin
                    o_out_valid[f] <= 1'b0;
                end
            end
            if (w_gnt && i_fifo_dout[DATA_WIDTH +: TAG_WIDTH] != w_idx)
                o_tag_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched: directed scenario bench for fifo_rd_sched (FLUX=2, QUANTUM=4 and 2)
module tb_fifo_rd_sched;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b0;
    logic            en2 = 1'b0;
    logic            bad_tag = 1'b0;
    logic [1:0]      empty = 2'b11;
    logic [1:0]      empty2 = 2'b11;
    logic [1:0]      ready = 2'b11;
    logic [1:0]      fr, ov, fr2, ov2;
    logic [1:0][7:0] od, od2;
    logic            cf, cf2, busy, busy2, te, te2;
    logic [7:0]      d0 = 8'h00;
    logic [7:0]      d1 = 8'h00;
    logic [8:0]      dout, dout2;
    int              n_tests = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    // Behaves like the FIFO: tag follows the strobed flux unless corrupted on purpose.
    assign dout  = {fr[1] ^ bad_tag, fr[1] ? d1 : d0};
    assign dout2 = {fr2[1], fr2[1] ? d1 : d0};

    fifo_rd_sched #(.DATA_WIDTH(8), .FLUX(2), .QUANTUM(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fifo_empty(empty),
        .i_fifo_dout(dout), .o_fifo_read(fr), .o_out_valid(ov), .o_out_data(od),
        .i_out_ready(ready), .o_cur_flux(cf), .o_busy(busy), .o_tag_err(te)
    );

    fifo_rd_sched #(.DATA_WIDTH(8), .FLUX(2), .QUANTUM(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .i_fifo_empty(empty2),
        .i_fifo_dout(dout2), .o_fifo_read(fr2), .o_out_valid(ov2), .o_out_data(od2),
        .i_out_ready(2'b11), .o_cur_flux(cf2), .o_busy(busy2), .o_tag_err(te2)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] exp;
        en = 1'b1; ready = 2'b11; empty = 2'b00; bad_tag = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2;
        n_tests++; if (fr !== 2'b00) begin n_fail++; $display("FAIL rst_read: fifo_read=%b want 00", fr); end
        n_tests++; if (ov !== 2'b00) begin n_fail++; $display("FAIL rst_valid: out_valid=%b want 00", ov); end
        n_tests++; if (od !== 16'h0) begin n_fail++; $display("FAIL rst_data: out_data=%h want 0000", od); end
        n_tests++; if (te !== 1'b0 || busy !== 1'b0 || cf !== 1'b0) begin
            n_fail++; $display("FAIL rst_flags: tag_err=%b busy=%b cur=%b want 0 0 0", te, busy, cf);
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            d0 = 8'h10 + 8'(i);
            d1 = 8'h20 + 8'(i);
            #1;
            exp = ((i % 8) < 4) ? 2'b01 : 2'b10;
            n_tests++; if (fr !== exp) begin n_fail++; $display("FAIL rr_seq[%0d]: fifo_read=%b want %b", i, fr, exp); end
            if (i == 0) begin
                n_tests++; if (ov !== 2'b00 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL first_cycle: out_valid=%b busy=%b want 00 0", ov, busy);
                end
            end
            if (i == 1) begin
                n_tests++; if (ov[0] !== 1'b1 || od[0] !== 8'h10 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL latency: valid0=%b data0=%h busy=%b want 1 10 1", ov[0], od[0], busy);
                end
            end
            if (i == 5) begin
                n_tests++; if (ov[1] !== 1'b1 || od[1] !== 8'h24) begin
                    n_fail++; $display("FAIL flux1_data: valid1=%b data1=%h want 1 24", ov[1], od[1]);
                end
            end
        end
        n_tests++; if (te !== 1'b0) begin n_fail++; $display("FAIL no_tag_err: tag_err=%b want 0", te); end
    endtask

    task automatic test_backpressure();
        logic       got;
        logic [7:0] exp1;
        got = 1'b0; exp1 = 8'h00;
        en = 1'b1; ready = 2'b11; empty = 2'b01; d1 = 8'h5A; d0 = 8'h00;
        do_reset();
        n_tests++; if (fr !== 2'b10) begin n_fail++; $display("FAIL bp_first: fifo_read=%b want 10", fr); end
        cyc();
        ready = 2'b01; empty = 2'b00;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            d1 = 8'hC0 + 8'(i);
            d0 = 8'h30 + 8'(i);
            #1;
            n_tests++; if (fr !== 2'b01 || ov[1] !== 1'b1 || od[1] !== 8'h5A) begin
                n_fail++; $display("FAIL bp_stall[%0d]: fifo_read=%b valid1=%b data1=%h want 01 1 5a", i, fr, ov[1], od[1]);
            end
        end
        cyc();
        ready = 2'b11;
        for (int i = 0; i < 4 && !got; i++) begin
            if (i > 0) cyc();
            d1 = 8'hB0 + 8'(i);
            #1;
            if (fr === 2'b10) begin got = 1'b1; exp1 = d1; end
        end
        n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL bp_release: flux1 granted=%b within 4 cycles want 1", got); end
        cyc();
        #1;
        n_tests++; if (got && (ov[1] !== 1'b1 || od[1] !== exp1)) begin
            n_fail++; $display("FAIL bp_capture: valid1=%b data1=%h want 1 %h", ov[1], od[1], exp1);
        end
    endtask

    task automatic test_single();
        en = 1'b0; en2 = 1'b1; empty2 = 2'b01;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            d1 = 8'h60 + 8'(i);
            #1;
            n_tests++; if (fr2 !== 2'b10) begin n_fail++; $display("FAIL single[%0d]: fifo_read=%b want 10", i, fr2); end
        end
        cyc();
        en2 = 1'b0; empty2 = 2'b11;
        #1;
        n_tests++; if (ov2 !== 2'b10 || od2[1] !== 8'h67 || busy2 !== 1'b1 || cf2 !== 1'b1 || te2 !== 1'b0) begin
            n_fail++; $display("FAIL single_out: valid=%b data1=%h busy=%b cur=%b tag_err=%b want 10 67 1 1 0",
                               ov2, od2[1], busy2, cf2, te2);
        end
    endtask

    task automatic test_tag();
        en = 1'b1; ready = 2'b11; empty = 2'b01; d1 = 8'hA5; bad_tag = 1'b1;
        do_reset();
        n_tests++; if (fr !== 2'b10 || te !== 1'b0) begin
            n_fail++; $display("FAIL tag_grant: fifo_read=%b tag_err=%b want 10 0", fr, te);
        end
        cyc();
        bad_tag = 1'b0; empty = 2'b11;
        #1;
        n_tests++; if (od[1] !== 8'hA5 || ov[1] !== 1'b1 || te !== 1'b1) begin
            n_fail++; $display("FAIL tag_set: data1=%h valid1=%b tag_err=%b want a5 1 1", od[1], ov[1], te);
        end
        empty = 2'b00;
        repeat (3) cyc();
        n_tests++; if (te !== 1'b1) begin n_fail++; $display("FAIL tag_sticky: tag_err=%b want 1", te); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (te !== 1'b0) begin n_fail++; $display("FAIL tag_clear: tag_err=%b want 0", te); end
    endtask

    task automatic test_en();
        en = 1'b1; ready = 2'b11; empty = 2'b00; d0 = 8'h11;
        do_reset();
        n_tests++; if (fr !== 2'b01) begin n_fail++; $display("FAIL en_first: fifo_read=%b want 01", fr); end
        cyc();
        #1;
        n_tests++; if (fr !== 2'b01 || busy !== 1'b1) begin
            n_fail++; $display("FAIL en_burst: fifo_read=%b busy=%b want 01 1", fr, busy);
        end
        cyc();
        en = 1'b0;
        #1;
        n_tests++; if (fr !== 2'b00) begin n_fail++; $display("FAIL en_off: fifo_read=%b want 00", fr); end
        cyc();
        #1;
        n_tests++; if (busy !== 1'b0 || fr !== 2'b00 || ov !== 2'b00 || cf !== 1'b0) begin
            n_fail++; $display("FAIL en_idle: busy=%b fifo_read=%b valid=%b cur=%b want 0 00 00 0", busy, fr, ov, cf);
        end
        en = 1'b1;
        #1;
        n_tests++; if (fr !== 2'b10) begin n_fail++; $display("FAIL en_resume: fifo_read=%b want 10", fr); end
        cyc();
        #1;
        n_tests++; if (fr !== 2'b10 || busy !== 1'b1 || ov[1] !== 1'b1) begin
            n_fail++; $display("FAIL en_resume2: fifo_read=%b busy=%b valid1=%b want 10 1 1", fr, busy, ov[1]);
        end
    endtask

    task automatic test_async();
        en = 1'b1; ready = 2'b11; empty = 2'b00; d0 = 8'h77; d1 = 8'h88;
        do_reset();
        repeat (5) cyc();
        #1;
        n_tests++; if (fr !== 2'b10 || od[0] !== 8'h77) begin
            n_fail++; $display("FAIL async_pre: fifo_read=%b data0=%h want 10 77", fr, od[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (ov !== 2'b00 || od !== 16'h0 || busy !== 1'b0 || fr !== 2'b00 || cf !== 1'b0) begin
            n_fail++; $display("FAIL async_clear: valid=%b data=%h busy=%b fifo_read=%b cur=%b want 00 0000 0 00 0",
                               ov, od, busy, fr, cf);
        end
        @(posedge clk);
        #4 rst_n = 1'b1;
        #1;
        n_tests++; if (fr !== 2'b01) begin n_fail++; $display("FAIL async_first: fifo_read=%b want 01", fr); end
        cyc();
        #1;
        n_tests++; if (ov !== 2'b01 || od[0] !== 8'h77) begin
            n_fail++; $display("FAIL async_capture: valid=%b data0=%h want 01 77", ov, od[0]);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_single();
        test_tag();
        test_en();
        test_async();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
